// File: rtl/exhaustive_resp_checker_if.sv
// exhaustive_resp_checker_if: vector/response bus between the sweep driver and the response checker
interface exhaustive_resp_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int CNT_W = 4
);
  logic             start;
  logic             vec_valid;
  logic [N_IN-1:0]  vec_idx;
  logic [N_OUT-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_err_idx;
  logic             first_err_vld;
  logic             seq_err;
  logic [15:0]      sig;
  modport master (
    output start, vec_valid, vec_idx, resp,
    input  busy, done, pass, err_cnt, first_err_idx, first_err_vld, seq_err, sig
  );
  modport slave (
    input  start, vec_valid, vec_idx, resp,
    output busy, done, pass, err_cnt, first_err_idx, first_err_vld, seq_err, sig
  );
endinterface

// File: rtl/exhaustive_resp_checker.sv
// exhaustive_resp_checker: checks an exhaustive sweep's responses against a golden table; CHK_MISR_EN adds a 16-bit MISR signature
module exhaustive_resp_checker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = 16'hE4E4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  exhaustive_resp_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nxt;
  logic [N_IN-1:0]  exp_idx;
  logic [N_OUT-1:0] exp_resp;
  logic [CNT_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_err_idx;
  logic             first_err_vld;
  logic             seq_err;
  logic             pass;
  logic             launch, acc, last, mis, oos;
  // Golden lookup uses the index the driver reports, so a misordered sample is still judged on its own vector
  always_comb begin
    exp_resp  = EXP_TABLE[int'(bus.vec_idx)*N_OUT +: N_OUT];
    launch    = state != RUN && bus.start;
    acc       = state == RUN && bus.vec_valid;
    last      = exp_idx == {N_IN{1'b1}};
    mis       = bus.resp != exp_resp;
    oos       = bus.vec_idx != exp_idx;
    state_nxt = launch ? RUN : (acc && last) ? DONE : state;
  end
  // State and result registers; launch clears everything, each accepted sample updates the tallies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      exp_idx       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      seq_err       <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        exp_idx       <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
        seq_err       <= 1'b0;
        pass          <= 1'b0;
      end else if (acc) begin
        exp_idx <= exp_idx + 1'b1;
        if (oos) seq_err <= 1'b1;
        if (mis && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
        if (mis && !first_err_vld) begin
          first_err_idx <= bus.vec_idx;
          first_err_vld <= 1'b1;
        end
        if (last) pass <= err_cnt == '0 && !mis && !seq_err && !oos;
      end
    end
  end
`ifdef CHK_MISR_EN
  logic [15:0] sig;
  // MISR over x^16+x^12+x^5+1, seeded on launch, folding in each accepted response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig <= '0;
    else if (launch) sig <= 16'hFFFF;
    else if (acc) sig <= {sig[14:0], sig[15] ^ sig[11] ^ sig[4]} ^ 16'(bus.resp);
  end
  assign bus.sig = sig;
`else
  assign bus.sig = 16'h0000;
`endif
  assign bus.busy          = state == RUN;
  assign bus.done          = state == DONE;
  assign bus.pass          = pass;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_idx = first_err_idx;
  assign bus.first_err_vld = first_err_vld;
  assign bus.seq_err       = seq_err;
endmodule
